priority_encoder_serializer: RTL

PRIORITY_ENCODER_SERIALIZER -- requirements
Module: priority_encoder_serializer

---
 rtl/priority_encoder_serializer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/priority_encoder_serializer.sv
`timescale 1ns/1ps
// priority_encoder_serializer
//
// Captures an n-bit request vector and emits the binary index of every
// set bit, lowest index first, one index per send handshake. The final
// index of a captured vector is flagged with send_last.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   recv_val   in   upstream vector valid
//   recv_rdy   out  block can accept a vector (IDLE and not in reset)
//   recv_msg   in   [n-1:0] request vector, one request per set bit
//   send_val   out  encoded index valid
//   send_rdy   in   downstream ready
//   send_msg   out  [m-1:0] index of the lowest pending set bit
//   send_last  out  current index is the final one of the vector
//
// The send_* outputs are registered and are computed from the next state
// and next pending value, so they depend only on state and pending and
// present no combinational path from any input.

module priority_encoder_serializer #(
  parameter int m = 3,
  parameter int n = 1 << m
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] recv_msg,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [m-1:0] send_msg,
  output logic         send_last
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [n-1:0]   pending_r;
  logic [n-1:0]   pending_nxt_s;
  logic           send_val_r;
  logic [m-1:0]   send_msg_r;
  logic           send_last_r;
  logic           send_val_nxt_s;
  logic [m-1:0]   send_msg_nxt_s;
  logic           send_last_nxt_s;
  logic           send_hs_s;

  // Index of the lowest-numbered set bit; zero for an all-zero vector.
  // Scanning from the top down lets the lowest set bit win.
  function automatic logic [m-1:0] lowest_index(input logic [n-1:0] vec);
    logic [m-1:0] idx;
    idx = {m{1'b0}};
    for (int i = n - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = m'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Vector with its lowest set bit removed.
  function automatic logic [n-1:0] clear_lowest(input logic [n-1:0] vec);
    return vec & (vec - {{(n-1){1'b0}}, 1'b1});
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic is_single(input logic [n-1:0] vec);
    return (vec != {n{1'b0}}) && (clear_lowest(vec) == {n{1'b0}});
  endfunction

  assign send_hs_s = send_val_r & send_rdy;

  // Next-state, next-pending and next-output computation.
  always_comb begin
    state_nxt_s     = state_r;
    pending_nxt_s   = pending_r;
    send_val_nxt_s  = 1'b0;
    send_msg_nxt_s  = {m{1'b0}};
    send_last_nxt_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (recv_val) begin
          // An all-zero vector is captured but produces no beat.
          pending_nxt_s = recv_msg;
          if (recv_msg != {n{1'b0}}) begin
            state_nxt_s = BUSY;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s   = IDLE;
          pending_nxt_s = pending_r;
        end
      end
      BUSY: begin
        // recv_val/recv_msg are deliberately ignored here.
        if (send_hs_s) begin
          pending_nxt_s = clear_lowest(pending_r);
          if (is_single(pending_r)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = BUSY;
          end
        end else begin
          state_nxt_s   = BUSY;
          pending_nxt_s = pending_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = {n{1'b0}};
      end
    endcase

    if (state_nxt_s == BUSY) begin
      send_val_nxt_s  = 1'b1;
      send_msg_nxt_s  = lowest_index(pending_nxt_s);
      send_last_nxt_s = is_single(pending_nxt_s);
    end else begin
      send_val_nxt_s  = 1'b0;
      send_msg_nxt_s  = {m{1'b0}};
      send_last_nxt_s = 1'b0;
    end
  end

  // FSM state, pending vector and registered send outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      pending_r   <= {n{1'b0}};
      send_val_r  <= 1'b0;
      send_msg_r  <= {m{1'b0}};
      send_last_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pending_r   <= pending_nxt_s;
      send_val_r  <= send_val_nxt_s;
      send_msg_r  <= send_msg_nxt_s;
      send_last_r <= send_last_nxt_s;
    end
  end

  // recv_rdy is gated by reset so it reads 0 throughout reset and rises
  // as soon as reset is released, without waiting for a clock edge.
  assign recv_rdy  = (state_r == IDLE) & ~reset;
  assign send_val  = send_val_r;
  assign send_msg  = send_msg_r;
  assign send_last = send_last_r;

endmodule
